// File: rtl/adc_spi_reader_if.sv
// Signal bundle between the ADC SPI reader and its environment.
// master = reader side, slave = requester plus the ADC pins it talks to.
interface adc_spi_reader_if;
  logic       start_sample;
  logic       adc_miso;
  logic       adc_sclk;
  logic       adc_cs;
  logic [9:0] adc_data;
  logic       data_valid;
  logic       busy;

  modport master (
    input  start_sample, adc_miso,
    output adc_sclk, adc_cs, adc_data, data_valid, busy
  );

  modport slave (
    output start_sample, adc_miso,
    input  adc_sclk, adc_cs, adc_data, data_valid, busy
  );
endinterface

// File: rtl/adc_spi_reader.sv
// Mode-0 SPI reader for an MCP3001-class 10-bit ADC: one 16-bit frame per
// accepted request, result presented with a single-cycle valid strobe.
module adc_spi_reader #(
  parameter int CLK_DIV    = 6,
  parameter int FRAME_BITS = 16
) (
  input  logic              clk,
  input  logic              nrst,
  adc_spi_reader_if.master  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, HOLD} state_t;

  state_t                state, state_d;
  logic [7:0]            div_cnt, div_cnt_d;
  logic [4:0]            fall_cnt, fall_cnt_d;
  logic [FRAME_BITS-1:0] shift, shift_d;
  logic [1:0]            miso_sync;
  logic                  sclk_q, sclk_d;
  logic                  cs_q, cs_d;
  logic [9:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  half_done;

  assign half_done = (div_cnt == 8'(CLK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      fall_cnt  <= '0;
      shift     <= '0;
      miso_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_d;
      div_cnt   <= div_cnt_d;
      fall_cnt  <= fall_cnt_d;
      shift     <= shift_d;
      miso_sync <= {miso_sync[0], bus.adc_miso};
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d    = state;
    div_cnt_d  = div_cnt;
    fall_cnt_d = fall_cnt;
    shift_d    = shift;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;

    unique case (state)
      IDLE: begin
        if (bus.start_sample) begin
          state_d    = SETUP;
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          div_cnt_d  = '0;
          fall_cnt_d = '0;
        end
      end
      SETUP: begin
        // CS-to-first-SCLK setup time, one half-period long.
        if (half_done) begin
          sclk_d    = 1'b1;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end else begin
          div_cnt_d = div_cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (half_done) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          // Sample at the end of the high phase; the ADC updates after the fall.
          if (sclk_q) begin
            shift_d    = {shift[FRAME_BITS-2:0], miso_sync[1]};
            fall_cnt_d = fall_cnt + 5'd1;
            if (fall_cnt == 5'(FRAME_BITS - 1)) state_d = DONE;
          end
        end else begin
          div_cnt_d = div_cnt + 8'd1;
        end
      end
      DONE: begin
        cs_d      = 1'b1;
        data_d    = shift[12:3];
        valid_d   = 1'b1;
        div_cnt_d = '0;
        state_d   = HOLD;
      end
      HOLD: begin
        if (half_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          div_cnt_d = div_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.adc_sclk   = sclk_q;
  assign bus.adc_cs     = cs_q;
  assign bus.adc_data   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Scoreboard bench for adc_spi_reader: two builds (CLK_DIV 6 and 4) driven by
// a behavioural ADC model, with a negedge monitor checking data and timing.
module tb_adc_spi_reader;
  localparam int DIV0 = 6;
  localparam int DIV1 = 4;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  adc_spi_reader_if b0 ();
  adc_spi_reader_if b1 ();

  adc_spi_reader #(.CLK_DIV(DIV0), .FRAME_BITS(16)) dut0 (.clk(clk), .nrst(nrst), .bus(b0.master));
  adc_spi_reader #(.CLK_DIV(DIV1), .FRAME_BITS(16)) dut1 (.clk(clk), .nrst(nrst), .bus(b1.master));

  int checks   = 0;
  int failures = 0;
  bit aborting = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ADC model: b15 presented at CS fall, next bit after every SCLK fall.
  logic [15:0] frame_q0[$], frame_q1[$];
  logic [9:0]  exp_q0[$], exp_q1[$];
  logic [15:0] frm0 = '0, frm1 = '0;
  logic [3:0]  idx0 = 4'd15, idx1 = 4'd15;

  assign b0.adc_miso = frm0[idx0];
  assign b1.adc_miso = frm1[idx1];

  always @(negedge b0.adc_cs) begin
    frm0 = (frame_q0.size() > 0) ? frame_q0.pop_front() : 16'h0000;
    idx0 = 4'd15;
  end
  always @(negedge b0.adc_sclk) if (idx0 != 4'd0) idx0 = idx0 - 4'd1;

  always @(negedge b1.adc_cs) begin
    frm1 = (frame_q1.size() > 0) ? frame_q1.pop_front() : 16'h0000;
    idx1 = 4'd15;
  end
  always @(negedge b1.adc_sclk) if (idx1 != 4'd0) idx1 = idx1 - 4'd1;

  // Reference model: the ADC emits 3 lead bits, D9..D0, then 3 trailing bits;
  // the reader must return D9..D0 whatever the surrounding bits are.
  task automatic issue(input int u, input logic [9:0] d, input logic [2:0] lead,
                       input logic [2:0] trail, input bit expect_it);
    logic [15:0] f;
    f = {lead, d, trail};
    if (u == 0) begin
      frame_q0.push_back(f);
      if (expect_it) exp_q0.push_back(d);
    end else begin
      frame_q1.push_back(f);
      if (expect_it) exp_q1.push_back(d);
    end
  endtask

  // Monitor state, one slot per build.
  int         cyc [2]       = '{0, 0};
  int         t_acc [2]     = '{0, 0};
  int         t_tog [2]     = '{0, 0};
  int         t_csr [2]     = '{0, 0};
  int         rises [2]     = '{0, 0};
  int         valid_cnt [2] = '{0, 0};
  logic       p_busy [2]    = '{1'b0, 1'b0};
  logic       p_sclk [2]    = '{1'b0, 1'b0};
  logic       p_cs [2]      = '{1'b1, 1'b1};
  logic       p_valid [2]   = '{1'b0, 1'b0};
  logic [9:0] p_data [2]    = '{10'h0, 10'h0};

  task automatic mon_step(input int u, input int d, input logic cs, input logic sclk,
                          input logic busy, input logic valid, input logic [9:0] data);
    int         now;
    bit         have;
    logic [9:0] e;
    cyc[u]++;
    now  = cyc[u];
    have = 1'b0;
    e    = '0;
    if (!aborting) begin
      check("sclk_high_while_cs_high", {31'd0, sclk & cs}, 32'd0);
      if (cs && !p_cs[u]) t_csr[u] = now;
      if (busy && !p_busy[u]) begin
        t_acc[u] = now;
        t_tog[u] = now;
        rises[u] = 0;
        check("cs_low_on_accept", {31'd0, cs}, 32'd0);
        check("sclk_low_on_accept", {31'd0, sclk}, 32'd0);
        if (t_csr[u] > 0) check("cs_high_gap_min", {31'd0, (now - t_csr[u]) >= d + 1}, 32'd1);
      end
      if (sclk !== p_sclk[u]) begin
        check("sclk_half_period", now - t_tog[u], d);
        t_tog[u] = now;
        if (sclk) rises[u]++;
      end
      if (valid) begin
        valid_cnt[u]++;
        check("valid_one_cycle", {31'd0, p_valid[u]}, 32'd0);
        check("valid_latency", now - t_acc[u], 32 * d + 1);
        check("sclk_rises_per_frame", rises[u], 16);
        check("cs_high_with_valid", {31'd0, cs}, 32'd1);
        if (u == 0) begin
          have = exp_q0.size() > 0;
          if (have) e = exp_q0.pop_front();
        end else begin
          have = exp_q1.size() > 0;
          if (have) e = exp_q1.pop_front();
        end
        check("valid_has_expected", {31'd0, have}, 32'd1);
        if (have) check("adc_data", {22'd0, data}, {22'd0, e});
      end else begin
        check("adc_data_hold", {22'd0, data}, {22'd0, p_data[u]});
      end
      if (!busy && p_busy[u]) check("busy_duration", now - t_acc[u], 33 * d + 1);
    end
    p_busy[u]  = busy;
    p_sclk[u]  = sclk;
    p_cs[u]    = cs;
    p_valid[u] = valid;
    p_data[u]  = data;
  endtask

  always @(negedge clk) begin
    mon_step(0, DIV0, b0.adc_cs, b0.adc_sclk, b0.busy, b0.data_valid, b0.adc_data);
    mon_step(1, DIV1, b1.adc_cs, b1.adc_sclk, b1.busy, b1.data_valid, b1.adc_data);
  end

  task automatic pulse(input int u);
    @(negedge clk);
    if (u == 0) b0.start_sample = 1'b1; else b1.start_sample = 1'b1;
    @(negedge clk);
    if (u == 0) b0.start_sample = 1'b0; else b1.start_sample = 1'b0;
  endtask

  task automatic wait_done(input int u, input int budget);
    int  n;
    bit  pending;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      pending = (u == 0) ? (b0.busy || exp_q0.size() != 0) : (b1.busy || exp_q1.size() != 0);
    end while (pending && n < budget);
    check("frame_done_within_budget", {31'd0, n < budget}, 32'd1);
  endtask

  task automatic one_frame(input int u, input logic [9:0] d, input logic [2:0] lead,
                           input logic [2:0] trail);
    issue(u, d, lead, trail, 1'b1);
    pulse(u);
    wait_done(u, 400);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, cnt, acc, vcnt;
    logic last;

    nrst = 1'b0;
    b0.start_sample = 1'b0;
    b1.start_sample = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs0", {31'd0, b0.adc_cs}, 32'd1);
    check("rst_sclk0", {31'd0, b0.adc_sclk}, 32'd0);
    check("rst_data0", {22'd0, b0.adc_data}, 32'd0);
    check("rst_valid0", {31'd0, b0.data_valid}, 32'd0);
    check("rst_busy0", {31'd0, b0.busy}, 32'd0);
    check("rst_cs1", {31'd0, b1.adc_cs}, 32'd1);
    check("rst_sclk1", {31'd0, b1.adc_sclk}, 32'd0);
    check("rst_data1", {22'd0, b1.adc_data}, 32'd0);
    check("rst_valid1", {31'd0, b1.data_valid}, 32'd0);
    check("rst_busy1", {31'd0, b1.busy}, 32'd0);
    @(negedge clk) nrst = 1'b1;
    repeat (2) @(negedge clk);
    aborting = 1'b0;

    // Basic read and extremes on the default build.
    one_frame(0, 10'h2A5, 3'b110, 3'b011);
    one_frame(0, 10'h3FF, 3'b000, 3'b000);
    one_frame(0, 10'h000, 3'b111, 3'b111);

    // A request while busy must be dropped, not queued.
    vcnt = valid_cnt[0];
    issue(0, 10'h1C3, 3'(($urandom_range(0, 7))), 3'(($urandom_range(0, 7))), 1'b1);
    pulse(0);
    repeat (48) @(negedge clk);
    pulse(0);
    wait_done(0, 400);
    repeat (12) @(negedge clk);
    check("busy_reject_idle", {31'd0, b0.busy}, 32'd0);
    check("busy_reject_valid_count", valid_cnt[0] - vcnt, 1);

    // Back-to-back frames with start held high.
    vcnt = valid_cnt[0];
    issue(0, 10'h001, 3'b101, 3'b110, 1'b1);
    issue(0, 10'h200, 3'b011, 3'b001, 1'b1);
    issue(0, 10'h155, 3'b111, 3'b010, 1'b1);
    @(negedge clk);
    b0.start_sample = 1'b1;
    acc = 0; n = 0; last = b0.busy;
    while (acc < 3 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (b0.busy && !last) acc++;
      last = b0.busy;
    end
    b0.start_sample = 1'b0;
    check("b2b_accepts", acc, 3);
    wait_done(0, 400);
    check("b2b_valid_count", valid_cnt[0] - vcnt, 3);

    // Randomized frames.
    for (int i = 0; i < 3; i++) begin
      one_frame(0, 10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // Reset at the 8th SCLK rising edge discards the partial frame.
    issue(0, 10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
    vcnt = valid_cnt[0];
    pulse(0);
    cnt = 0; n = 0; last = b0.adc_sclk;
    while (cnt < 8 && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (b0.adc_sclk && !last) cnt++;
      last = b0.adc_sclk;
    end
    check("reached_8th_rise", cnt, 8);
    aborting = 1'b1;
    nrst = 1'b0;
    #1;
    check("midrst_cs", {31'd0, b0.adc_cs}, 32'd1);
    check("midrst_sclk", {31'd0, b0.adc_sclk}, 32'd0);
    check("midrst_busy", {31'd0, b0.busy}, 32'd0);
    check("midrst_data", {22'd0, b0.adc_data}, 32'd0);
    check("midrst_valid", {31'd0, b0.data_valid}, 32'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    aborting = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_stays_idle", {31'd0, b0.busy}, 32'd0);
    check("midrst_no_valid", valid_cnt[0] - vcnt, 0);
    one_frame(0, 10'h0F0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    // Fastest legal divider.
    one_frame(1, 10'h2A5, 3'b110, 3'b011);
    for (int i = 0; i < 3; i++) begin
      one_frame(1, 10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard0_drained", exp_q0.size(), 0);
    check("scoreboard1_drained", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- SPI controller that reads one 10-bit sample from an MCP3001-class serial ADC per request. It is the read-side counterpart of the DAC write path.
- It runs in the system clock domain (12 MHz on the ECP5 board) and generates a mode-0 serial clock.
- It captures a 16-bit MISO frame, extracts the 10-bit result and presents it with a one-cycle valid strobe.
- The owning team project uses it to feed samples into the processing datapath that ultimately drives the DAC.

Parameters:
- CLK_DIV, 6, system-clock cycles per SCLK half-period. Default gives 1 MHz SCLK. Legal range 4..255.
- FRAME_BITS, 16, SCLK cycles per frame. Fixed at 16 for this ADC; other values are unsupported.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- start_sample  input  1  request one conversion; level-sampled, accepted only in IDLE
- adc_miso  input  1  ADC serial data out; asynchronous to clk
- adc_sclk  output  1  SPI clock, idle low
- adc_cs  output  1  SPI chip select, active low
- adc_data  output  10  last captured sample, held until the next frame completes
- data_valid  output  1  one-cycle pulse when adc_data updates
- busy  output  1  high from request acceptance through the CS-high hold

Behaviour:
- Clock and reset: one clock (clk). Reset (nrst) is asynchronous, active-low. All outputs and state are registered.
- Reset values: adc_cs=1, adc_sclk=0, adc_data=0, data_valid=0, busy=0, state=IDLE. Shift register, counters and synchronizer are cleared.
- Input synchronizer: adc_miso passes through a 2-flop synchronizer. CLK_DIV>=4 guarantees that the synced bit settles inside the half-period.
- States: IDLE -> SETUP -> SHIFT -> DONE -> HOLD -> IDLE.
- IDLE: adc_cs=1, adc_sclk=0.
  - start_sample=1 sampled at edge E0 -> SETUP. On E0, adc_cs<=0, busy<=1, half-period counter<=0.
- SETUP: waits CLK_DIV cycles (tSUCS). At edge E0+CLK_DIV: adc_sclk<=1 (first rising edge) -> SHIFT.
- SHIFT: adc_sclk toggles every CLK_DIV cycles. The first toggle is at E0+CLK_DIV and toggle k is at E0+k*CLK_DIV, giving 32 toggles.
  - On every 1->0 toggle (end of the high phase), the synced MISO bit is shifted in MSB-first.
  - A bit counter counts falling edges. The 16th falling edge, at E0+32*CLK_DIV, captures the last bit -> DONE.
- Frame layout as captured, b15 first:
  - b15..b13: sample and null bits, discarded.
  - b12..b3: D9..D0.
  - b2..b0: discarded (LSB-first repeat / trailing bits).
- DONE (one cycle, at edge E0+32*CLK_DIV+1): adc_cs<=1, adc_data<=shift[12:3], data_valid<=1. Latency from acceptance to data_valid = 32*CLK_DIV+1 cycles (193 at default).
- HOLD: adc_cs stays high for CLK_DIV cycles (tCSH). busy<=0 at E0+33*CLK_DIV+1, entering IDLE.
- data_valid is high for exactly one cycle per frame. It is never asserted without a complete 16-bit frame.
- start_sample while busy=1 is ignored, not queued.
- start_sample held high continuously gives back-to-back frames: the next acceptance occurs in the first IDLE cycle, so CS-high is CLK_DIV+1 cycles minimum.
- Reset asserted mid-frame: immediately adc_cs=1, adc_sclk=0, busy=0, data_valid=0. adc_data returns to 0. The partial frame is discarded. After release, the block waits in IDLE for a new start_sample.
- adc_sclk is never toggled while adc_cs=1. adc_cs never falls while adc_sclk=1.

Test Plan:
- Basic read, CLK_DIV=6: the ADC model drives frame b15..b0 = 0b110_1010100101_011, i.e. data 0x2A5. MISO changes only after falling edges; b15 is valid at CS fall. Pulse start_sample for 1 cycle -> exactly 16 SCLK rising edges, each high and low phase 6 cycles; data_valid at 193 cycles after acceptance; adc_data=0x2A5; adc_cs high at the same edge; busy low at 199.
- Extremes: data 0x3FF with b15..b13=000 and b2..b0=000 -> adc_data=0x3FF. Data 0x000 with discard bits all 1 -> adc_data=0x000 (discard bits never leak).
- Busy rejection: pulse start_sample again at cycle 50 of a frame -> no extra SCLK edges, exactly one data_valid, busy timing unchanged.
- Back-to-back: start_sample held high for three frames with data 0x001, 0x200, 0x155 -> three data_valid pulses with the matching values; CS-high gap between frames >= 7 cycles; adc_data holds between pulses.
- Mid-frame reset: assert nrst at the 8th SCLK rising edge -> same cycle adc_cs=1, adc_sclk=0, busy=0, adc_data=0, no data_valid. After release and a new start, a full correct frame with data 0x0F0 completes.
- CLK_DIV=4 build: repeat the basic read -> SCLK half-period 4 cycles, data_valid at 129 cycles, adc_data correct despite the 2-flop sync latency.
